// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Write-back stage in front of the register file, and the only driver of its
//   A3/WD3/WE3 write port. It merges single-cycle ALU results with load data
//   that the data cache returns after a variable delay. Outstanding loads are
//   kept in order in a small pending FIFO, and each returned word is sign- or
//   zero-extended for its load type before it is written. Source registers
//   A1/A2 are compared against every write still pending so that decode can
//   stall on a read-after-write hazard.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-low reset
//   alu_valid/alu_rd/alu_result   single-cycle ALU result
//   ld_issue/ld_rd/ld_funct3/ld_addr_lo   load issued to the cache
//   mem_ready/mem_rdata       cache data for the oldest outstanding load
//   A1, A2                    decode source registers
//   A3, WD3, WE3              registered register-file write port
//   stall                     upstream must not issue next cycle
//   hazard1, hazard2          A1/A2 have a pending write (combinational)
//   err                       sticky protocol-violation flag
module reg_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_result,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_rd,
    input  logic [2:0]    ld_funct3,
    input  logic [1:0]    ld_addr_lo,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD3,
    output logic          WE3,
    output logic          stall,
    output logic          hazard1,
    output logic          hazard2,
    output logic          err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pending-load FIFO storage
    logic [AW-1:0] fifo_rd_q [DEPTH];
    logic [AW-1:0] fifo_rd_d [DEPTH];
    logic [2:0]    fifo_f3_q [DEPTH];
    logic [2:0]    fifo_f3_d [DEPTH];
    logic [1:0]    fifo_lo_q [DEPTH];
    logic [1:0]    fifo_lo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // One-entry hold for an ALU result that lost arbitration
    logic          hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_rd_q, hold_rd_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          we3_q, we3_d;
    logic          stall_q, stall_d;
    logic          err_q, err_d;

    logic          pop;
    logic          push;
    logic          full;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] ld_data;

    function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] word,
                                                  input logic [2:0]    f3,
                                                  input logic [1:0]    lo);
        logic [7:0]    lane_b;
        logic [15:0]   lane_h;
        logic [DW-1:0] res;
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(DW-8){lane_b[7]}}, lane_b};
            3'b100:  res = {{(DW-8){1'b0}}, lane_b};
            3'b001:  res = {{(DW-16){lane_h[15]}}, lane_h};
            3'b101:  res = {{(DW-16){1'b0}}, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        fifo_rd_d    = fifo_rd_q;
        fifo_f3_d    = fifo_f3_q;
        fifo_lo_d    = fifo_lo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        we3_d        = 1'b0;

        full    = (count_q == CW'(DEPTH));
        // An empty FIFO is never popped, even when a push lands in the same
        // cycle: that response cannot belong to the load being issued now.
        pop     = mem_ready && (count_q != '0);
        push    = ld_issue && (!full || pop);
        head_rd = fifo_rd_q[rd_ptr_q];
        ld_data = extend_load(mem_rdata, fifo_f3_q[rd_ptr_q], fifo_lo_q[rd_ptr_q]);

        err_d = err_q
              | (mem_ready && (count_q == '0))
              | (ld_issue && full && !pop);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (head_rd != '0) begin
                we3_d = 1'b1;
                a3_d  = head_rd;
                wd3_d = ld_data;
            end
            if (alu_valid) begin
                if (hold_valid_q) begin
                    err_d = 1'b1;
                end else begin
                    hold_valid_d = 1'b1;
                    hold_rd_d    = alu_rd;
                    hold_data_d  = alu_result;
                end
            end
        end else if (hold_valid_q) begin
            // Hold drains this cycle, so a new ALU result can take its place.
            hold_valid_d = 1'b0;
            if (hold_rd_q != '0) begin
                we3_d = 1'b1;
                a3_d  = hold_rd_q;
                wd3_d = hold_data_q;
            end
            if (alu_valid) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = alu_rd;
                hold_data_d  = alu_result;
            end
        end else if (alu_valid && (alu_rd != '0)) begin
            we3_d = 1'b1;
            a3_d  = alu_rd;
            wd3_d = alu_result;
        end

        if (push) begin
            fifo_rd_d[wr_ptr_q] = ld_rd;
            fifo_f3_d[wr_ptr_q] = ld_funct3;
            fifo_lo_d[wr_ptr_q] = ld_addr_lo;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
        stall_d = (count_d == CW'(DEPTH)) || hold_valid_d;
    end

    // Hazard scan walks the live window starting at the head, so the entry
    // being popped this cycle is still counted.
    always_comb begin
        logic [PW-1:0] idx;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (fifo_rd_q[idx] == A1) hazard1 = 1'b1;
                if (fifo_rd_q[idx] == A2) hazard2 = 1'b1;
            end
        end
        if (hold_valid_q && (hold_rd_q == A1)) hazard1 = 1'b1;
        if (hold_valid_q && (hold_rd_q == A2)) hazard2 = 1'b1;
        if (A1 == '0) hazard1 = 1'b0;
        if (A2 == '0) hazard2 = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i] <= '0;
                fifo_f3_q[i] <= '0;
                fifo_lo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            a3_q         <= '0;
            wd3_q        <= '0;
            we3_q        <= 1'b0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            fifo_rd_q    <= fifo_rd_d;
            fifo_f3_q    <= fifo_f3_d;
            fifo_lo_q    <= fifo_lo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
            we3_q        <= we3_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
        end
    end

    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign WE3   = we3_q;
    assign stall = stall_q;
    assign err   = err_q;

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
Write-back stage directly upstream of the register file; it is the sole driver of the register file's A3/WD3/WE3 write port. It merges single-cycle ALU results with variable-latency load data returned by the data cache. Outstanding loads are tracked in an in-order pending FIFO, and loaded data is sign/zero-extended before write. It also flags read-after-write hazards on source registers A1/A2 so decode can stall.

Parameters:
DEPTH, 4, number of outstanding loads tracked (power of 2, >=2)
AW, 5, register index width
DW, 32, data width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  AW  ALU destination register
alu_result  in  DW  ALU result
ld_issue  in  1  load issued to cache this cycle
ld_rd  in  AW  load destination register
ld_funct3  in  3  load type (RISC-V funct3)
ld_addr_lo  in  2  load byte address [1:0]
mem_ready  in  1  cache returns data for oldest outstanding load
mem_rdata  in  DW  raw 32-bit word from cache
A1  in  AW  decode source register 1
A2  in  AW  decode source register 2
A3  out  AW  register file write address
WD3  out  DW  register file write data
WE3  out  1  register file write enable
stall  out  1  upstream must not assert alu_valid/ld_issue next cycle
hazard1  out  1  A1 has a pending write
hazard2  out  1  A2 has a pending write
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous, active-low, on RST; clock is CLK (rising edge).
- Reset values: A3=0, WD3=0, WE3=0, stall=0, err=0. FIFO is emptied and the hold register is invalidated. A reset mid-operation discards all pending loads; responses arriving afterwards count as an empty-FIFO mem_ready (see below).
- A3/WD3/WE3 are registered, with 1-cycle latency from the winning source.
- Write-source priority each cycle:
  - (1) load response (mem_ready && FIFO not empty);
  - (2) hold register;
  - (3) new ALU result.
- A losing new ALU result is captured into the 1-entry hold register. If the hold is already full and the ALU result loses again, it is dropped and err is set.
- Load response path:
  - Pop the FIFO head {rd, funct3, addr_lo} and select the lane from mem_rdata.
  - 000 LB: byte addr_lo, sign-extend. 100 LBU: byte addr_lo, zero-extend.
  - 001 LH: half addr_lo[1], sign-extend. 101 LHU: half addr_lo[1], zero-extend.
  - 010 LW and any other code: full word.
- rd==0: WE3 stays 0 and A3/WD3 hold their values. FIFO pop and hold clearing still occur.
- FIFO push on ld_issue:
  - Full with no pop in the same cycle: push dropped, err=1.
  - Full with a pop in the same cycle: push accepted.
- Simultaneous push and pop on an empty FIFO: the new entry is not popped. The response belongs to an earlier (nonexistent) load, so err=1.
- mem_ready with an empty FIFO: ignored, err=1.
- Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- stall (registered) = next-state (count==DEPTH) OR next-state hold_valid.
- hazard1 (combinational) = A1!=0 AND (A1 matches rd of any valid FIFO entry OR the valid hold rd). hazard2 is the same for A2. The FIFO head popped this cycle still counts.
- err stays set until reset.

Test Plan:
- ALU only: alu_valid, rd=5, result=0x1234 -> next cycle WE3=1, A3=5, WD3=0x1234. rd=0 -> WE3=0.
- LB sign/zero:
  - ld_issue rd=7, funct3=000, addr_lo=2; 3 cycles later mem_ready, rdata=0x00F00000 -> WE3=1, A3=7, WD3=0xFFFFFFF0.
  - Same stimulus with funct3=100 -> WD3=0x000000F0.
  - funct3=001, addr_lo=2, rdata=0x80000000 -> WD3=0xFFFF8000.
- Collision: mem_ready for rd=3 (LW, data 0xAA) with alu_valid rd=4 (0xBB) in the same cycle:
  - cycle+1: A3=3, WD3=0xAA;
  - cycle+2: A3=4, WD3=0xBB;
  - stall=1 for exactly the cycle the hold is valid.
- FIFO full: issue 4 loads (rd=1..4) -> stall=1 after the 4th; hazard1=1 for A1=3, 0 for A1=0 and for A1=9. Then 4 responses -> writes in order rd=1,2,3,4, stall drops, hazard clears.
- Errors: mem_ready with empty FIFO -> err=1, no write. 5th ld_issue while full with no pop -> err=1.
- Reset mid-operation: 2 loads pending, RST low -> all outputs 0 immediately, hazards 0; a subsequent mem_ready -> err=1.
